// File: rtl/uart_loader_if.sv
// Byte-stream loader bus: received-byte strobe/data in, instruction-memory write and status out.
// The loader drives the master side; the UART/memory/CPU environment is the slave side.
interface uart_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_busy;
    logic              load_ok;
    logic              load_err;
    logic [1:0]        err_code;

    modport master (
        input  rx_done, rx_data,
        output mem_we, mem_addr, mem_wdata, cpu_hold, load_busy, load_ok, load_err, err_code
    );

    modport slave (
        output rx_done, rx_data,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, load_busy, load_ok, load_err, err_code
    );
endinterface

// File: rtl/uart_loader.sv
// Framed program loader: SYNC, LEN_LO, LEN_HI, 4*N data bytes, XOR checksum.
// Packs little-endian words into instruction memory and holds the CPU in reset while loading.
module uart_loader #(
    parameter int         ADDR_W         = 12,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 3_000_000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_loader_if.master bus
);
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_N    = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              rx_prev_q;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              load_ok_q, load_ok_d;
    logic              load_err_q, load_err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              byte_v_s;
    logic [15:0]       n_s;
    logic [31:0]       word_next_s;

    function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*k +: 8] = b;
        return r;
    endfunction

    // A byte counts only on the rising edge of the level-style done flag.
    assign byte_v_s    = bus.rx_done & ~rx_prev_q;
    assign n_s         = {bus.rx_data, len_lo_q};
    assign word_next_s = put_lane(word_q, bidx_q, bus.rx_data);

    // Frame parser next-state and output decode.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        n_d         = n_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_ok_d   = 1'b0;
        load_err_d  = load_err_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (byte_v_s && (bus.rx_data == SYNC_BYTE)) begin
                    state_d    = S_LEN0;
                    cpu_hold_d = 1'b1;
                    load_err_d = 1'b0;
                    err_code_d = 2'd0;
                    widx_d     = '0;
                    bidx_d     = 2'd0;
                    csum_d     = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN0: begin
                if (byte_v_s) begin
                    len_lo_d = bus.rx_data;
                    state_d  = S_LEN1;
                end else begin
                    state_d = S_LEN0;
                end
            end
            S_LEN1: begin
                if (byte_v_s) begin
                    if ({1'b0, n_s} > MAX_N) begin
                        state_d    = S_IDLE;
                        cpu_hold_d = 1'b0;
                        load_err_d = 1'b1;
                        err_code_d = 2'd3;
                    end else if (n_s == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        n_d     = n_s[ADDR_W:0];
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN1;
                end
            end
            S_DATA: begin
                if (byte_v_s) begin
                    csum_d = csum_q ^ bus.rx_data;
                    word_d = word_next_s;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q[ADDR_W-1:0];
                        mem_wdata_d = word_next_s;
                        widx_d      = widx_q + (ADDR_W+1)'(1);
                        if ((widx_q + (ADDR_W+1)'(1)) == n_q) begin
                            state_d = S_CHK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (byte_v_s) begin
                    state_d    = S_IDLE;
                    cpu_hold_d = 1'b0;
                    if (bus.rx_data == csum_q) begin
                        load_ok_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                        err_code_d = 2'd1;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inter-byte watchdog; an accepted byte beats a simultaneous expiry.
        if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (byte_v_s) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d      = '0;
            state_d    = S_IDLE;
            cpu_hold_d = 1'b0;
            load_err_d = 1'b1;
            err_code_d = 2'd2;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            rx_prev_q   <= 1'b0;
            len_lo_q    <= 8'd0;
            n_q         <= '0;
            widx_q      <= '0;
            bidx_q      <= 2'd0;
            word_q      <= 32'd0;
            csum_q      <= 8'd0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= bus.rx_done;
            len_lo_q    <= len_lo_d;
            n_q         <= n_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            load_ok_q   <= load_ok_d;
            load_err_q  <= load_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.load_busy = busy_q;
    assign bus.load_ok   = load_ok_q;
    assign bus.load_err  = load_err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: a short-timeout and a long-timeout instance share one byte driver;
// expectations come from parsing each sent frame with plain arithmetic.
module tb_uart_loader;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       sel;

    int checks = 0;
    int errors = 0;

    logic [35:0] wr_q[$];
    int          ok_cnt = 0;
    logic [7:0]  frame_q[$];

    always #5 clk = ~clk;

    uart_loader_if #(.ADDR_W(AW)) if_a ();
    uart_loader_if #(.ADDR_W(AW)) if_b ();

    assign if_a.rx_done = rx_done & ~sel;
    assign if_b.rx_done = rx_done & sel;
    assign if_a.rx_data = rx_data;
    assign if_b.rx_data = rx_data;

    uart_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) u_fast (
        .sys_clk(clk), .sys_rst(rst), .bus(if_a));
    uart_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(2000)) u_slow (
        .sys_clk(clk), .sys_rst(rst), .bus(if_b));

    logic          cur_we, cur_hold, cur_busy, cur_ok, cur_err;
    logic [1:0]    cur_code;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    assign cur_we    = sel ? if_b.mem_we    : if_a.mem_we;
    assign cur_hold  = sel ? if_b.cpu_hold  : if_a.cpu_hold;
    assign cur_busy  = sel ? if_b.load_busy : if_a.load_busy;
    assign cur_ok    = sel ? if_b.load_ok   : if_a.load_ok;
    assign cur_err   = sel ? if_b.load_err  : if_a.load_err;
    assign cur_code  = sel ? if_b.err_code  : if_a.err_code;
    assign cur_addr  = sel ? if_b.mem_addr  : if_a.mem_addr;
    assign cur_wdata = sel ? if_b.mem_wdata : if_a.mem_wdata;

    // Collect every memory write and load_ok cycle from both instances.
    always @(negedge clk) begin
        if (if_a.mem_we) wr_q.push_back({if_a.mem_addr, if_a.mem_wdata});
        if (if_b.mem_we) wr_q.push_back({if_b.mem_addr, if_b.mem_wdata});
        if (if_a.load_ok) ok_cnt++;
        if (if_b.load_ok) ok_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic build_frame(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        frame_q = '{8'hA5, 8'(n), 8'(n >> 8)};
        if (n <= (1 << AW)) begin
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                frame_q.push_back(b);
                x = x ^ b;
            end
            if (bad) x = x ^ 8'(1 + $urandom_range(0, 254));
            frame_q.push_back(x);
        end
    endtask

    // Reference: parse the frame from its bytes, send it, compare writes and flags.
    task automatic run_frame(input string tag, input int hold);
        logic [35:0] exp_w[$];
        logic [7:0]  x;
        logic [31:0] w;
        int          n, base_w, base_ok, got_w;
        bit          exp_ok;
        logic [1:0]  exp_code;
        n = int'(frame_q[1]) + 256 * int'(frame_q[2]);
        if (n > (1 << AW)) begin
            exp_ok   = 1'b0;
            exp_code = 2'd3;
        end else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                w = {frame_q[3+4*i+3], frame_q[3+4*i+2], frame_q[3+4*i+1], frame_q[3+4*i]};
                exp_w.push_back({4'(i), w});
                x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
            exp_ok   = (frame_q[3+4*n] == x);
            exp_code = exp_ok ? 2'd0 : 2'd1;
        end
        base_w  = wr_q.size();
        base_ok = ok_cnt;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], hold);
            if (i == 0) check_eq({tag, "_hold_sync"}, cur_hold, 1'b1);
        end
        repeat (4) @(negedge clk);
        got_w = wr_q.size() - base_w;
        check_eq({tag, "_nwr"}, got_w, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w; i++)
            check_eq({tag, "_wr"}, wr_q[base_w+i], exp_w[i]);
        check_eq({tag, "_ok"}, ok_cnt - base_ok, exp_ok ? 1 : 0);
        check_eq({tag, "_err"}, cur_err, exp_code != 2'd0);
        check_eq({tag, "_code"}, cur_code, exp_code);
        check_eq({tag, "_hold_end"}, cur_hold, 1'b0);
        check_eq({tag, "_busy_end"}, cur_busy, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_we"}, cur_we, 1'b0);
        check_eq({tag, "_addr"}, cur_addr, '0);
        check_eq({tag, "_wdata"}, cur_wdata, 32'd0);
        check_eq({tag, "_hold"}, cur_hold, 1'b0);
        check_eq({tag, "_busy"}, cur_busy, 1'b0);
        check_eq({tag, "_ok"}, cur_ok, 1'b0);
        check_eq({tag, "_err"}, cur_err, 1'b0);
        check_eq({tag, "_code"}, cur_code, 2'd0);
    endtask

    initial begin
        int base_w;
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        sel     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_idle_outputs("rst");
        end
        sel = 1'b0;

        // Nominal frame, then the same frame with a long held done flag on the slow instance.
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        run_frame("t1", 1);
        sel = 1'b1;
        run_frame("t2", 500);
        sel = 1'b0;

        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h01};
        run_frame("t3", 1);

        // Byte timeout after one data byte, then SYNC clears the sticky error.
        base_w = wr_q.size();
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_byte(8'hAA, 1);
        repeat (90) @(negedge clk);
        check_eq("t4_err_early", cur_err, 1'b0);
        check_eq("t4_busy_early", cur_busy, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("t4_err", cur_err, 1'b1);
        check_eq("t4_code", cur_code, 2'd2);
        check_eq("t4_hold", cur_hold, 1'b0);
        check_eq("t4_nwr", wr_q.size() - base_w, 0);
        send_byte(8'hA5, 1);
        check_eq("t4_clr_err", cur_err, 1'b0);
        check_eq("t4_clr_code", cur_code, 2'd0);
        repeat (120) @(negedge clk);

        // Length limits: one above capacity rejected, exactly capacity accepted.
        build_frame((1 << AW) + 1, 1'b0);
        run_frame("t5_big", 1);
        build_frame(1 << AW, 1'b0);
        run_frame("t5_full", 1);

        for (int k = 0; k < 8; k++) begin
            build_frame($urandom_range(0, (1 << AW) + 1), ($urandom_range(0, 3) == 0));
            run_frame("rnd", $urandom_range(1, 3));
        end

        // Garbage before SYNC is ignored; reset mid-frame leaves only word 0 written.
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 1);
        check_eq("t6_garbage_busy", cur_busy, 1'b0);
        check_eq("t6_garbage_hold", cur_hold, 1'b0);
        base_w  = wr_q.size();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        foreach (frame_q[i]) send_byte(frame_q[i], 1);
        check_eq("t6_hold_mid", cur_hold, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        repeat (150) @(negedge clk);
        check_eq("t6_nwr", wr_q.size() - base_w, 1);
        if (wr_q.size() > base_w) check_eq("t6_wr0", wr_q[base_w], {4'd0, 32'h04030201});
        check_eq("t6_err_after", cur_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
